systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Edge feeder for an N×N systolic array of 16-bit multiply-accumulate PEs. It accepts one k-step per handshake: column k of A and row k of B as N-lane vectors. It drives the array's west and north edges with the diagonal skew the array needs, plus the shared clock-enable. After the last k-step it flushes zeros until every PE has absorbed its final product, then pulses done.

## Interface
- N, default 4: array dimension (lanes per edge), N ≥ 2.
- W, default 16: lane data width.
- K_W, default 8: width of the k-step count.
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a tile; sampled only in IDLE.
- k_len  input  K_W  number of k-steps; sampled with start.
- in_valid  input  1  a_vec/b_vec hold a valid k-step.
- in_ready  output  1  feeder accepts a k-step this cycle.
- a_vec  input  N*W  lane i = a_vec[i*W +: W] = A[i][k] (west, row i).
- b_vec  input  N*W  lane j = b_vec[j*W +: W] = B[k][j] (north, column j).
- west_out  output  N*W  skewed A lanes to the array's west edge.
- north_out  output  N*W  skewed B lanes to the array's north edge.
- ce  output  1  array clock-enable.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse: the tile has fully drained.

## Operation
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE:
  - start=1 and k_len≠0: latch k_len, clear the step counter, go to STREAM.
  - start=1 and k_len=0: go to DONE directly; no ce is issued.
- STREAM:
  - in_ready=1.
  - An advance occurs on each cycle with in_valid=1; that lane data enters the skew lines.
  - On the advance that accepts step k_len, load the flush counter with 2N−2 and go to FLUSH.
  - in_valid=0 means no advance: skew lines and outputs hold.
- FLUSH:
  - in_ready=0.
  - Advance every cycle, injecting zeros on all lanes.
  - After 2N−2 advances, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Skew lines:
  - Lane i (west and north alike) is a shift chain of i+1 registers.
  - The chain shifts only on an advance.
  - Data injected on advance t appears on lane i output after advance t+i.
- ce is the advance signal registered by one cycle. The array therefore samples each new edge value on the cycle after it appears.
- Flush length 2N−2 covers two delays: N−1 advances for the deepest skew lane, plus N−1 hops for data to cross the array to PE(N−1,N−1).
- Zero lanes contribute zero products, so accumulators are unaffected.
- Total ce-high cycles per tile = k_len + 2N − 2.
- start while busy is ignored. k_len and lane data are not re-sampled mid-tile.
- No arithmetic is performed; lane values pass through bit-exact.

## Timing
- Reset (async, rst_n=0):
  - state=IDLE, all counters 0.
  - west_out=0, north_out=0, ce=0, in_ready=0, busy=0, done=0.
  - Takes effect immediately, including mid-STREAM or mid-FLUSH.
  - Any partial tile is discarded.
- All outputs are registered except in_ready and busy, which decode state combinationally.
- start sampled at edge e: in_ready=1 from cycle e+1.
- Advance at edge t: lane 0 outputs update after t; ce=1 during cycle t+1.
- Last FLUSH advance at edge f: DONE, done=1 and the final ce=1 all occur in cycle f+1. Array results are final from cycle f+2.
- Back-to-back tiles:
  - A start in the DONE cycle is ignored.
  - A start accepted in IDLE the following cycle begins the next tile.

## Test plan
- Reset:
  - Assert rst_n=0 with random inputs.
  - Expect all outputs 0, in_ready=0.
  - Release; expect state stays IDLE with ce=0.
- N=4, single step:
  - start, k_len=1, then in_valid with a lanes {1,2,3,4} and b lanes {5,6,7,8} on the first STREAM cycle.
  - Expect west/north lane i nonzero only at i cycles after lane 0, and ce high for exactly 7 consecutive cycles.
  - Expect done in the last ce cycle.
- Backpressure:
  - k_len=3 with in_valid toggling 1,0,0,1,0,1.
  - Expect ce to mirror accepted steps one cycle later.
  - Expect outputs to hold during gaps and the total ce count to be 9.
- Zero length: start with k_len=0 -> done exactly one cycle later, ce never asserted, in_ready never 1.
- Control edge cases:
  - start pulsed during STREAM is ignored; the tile count is unchanged.
  - rst_n=0 mid-FLUSH clears outputs immediately; after release, a new tile runs correctly.
- End-to-end:
  - Drive a 4×4 grid of MAC PEs with A = identity and B = [[1..4],[5..8],[9..12],[13..16]], k_len=4.
  - After done, PE(i,j) results equal B[i][j].

Source files
------------

// File: rtl/systolic_feeder.sv
// Edge feeder for an N x N systolic MAC array: skews A/B k-step vectors onto the
// west/north edges, drives the shared clock-enable and flushes zeros to drain the tile.
module systolic_feeder #(
   parameter int N   = 4,
   parameter int W   = 16,
   parameter int K_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [K_W-1:0]   k_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N*W-1:0]   a_vec,
   input  logic [N*W-1:0]   b_vec,
   output logic [N*W-1:0]   west_out,
   output logic [N*W-1:0]   north_out,
   output logic             ce,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Flush must cover the deepest skew lane plus the diagonal hop count across the array.
   localparam int FL_W = $clog2(2 * N);
   localparam logic [FL_W-1:0] FLUSH_LEN = FL_W'(2 * N - 2);
   localparam logic [FL_W-1:0] FL_ONE    = FL_W'(1'b1);
   localparam logic [K_W-1:0]  K_ONE     = K_W'(1'b1);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [K_W-1:0]    k_len_r;
   logic [K_W-1:0]    step_cnt_r;
   logic [FL_W-1:0]   flush_cnt_r;
   logic              adv_s;
   logic              inject_s;
   logic              last_step_s;
   logic              ce_r;
   logic              done_r;
   logic [N*W-1:0]    inj_a_s;
   logic [N*W-1:0]    inj_b_s;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and advance generation.
   always_comb begin
      state_nxt_s = state_r;
      adv_s       = 1'b0;
      inject_s    = 1'b0;
      last_step_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (k_len != {K_W{1'b0}}) begin
                  state_nxt_s = STREAM;
               end else begin
                  state_nxt_s = DONE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         STREAM: begin
            if (in_valid) begin
               adv_s    = 1'b1;
               inject_s = 1'b1;
               if ((step_cnt_r + K_ONE) == k_len_r) begin
                  last_step_s = 1'b1;
                  state_nxt_s = FLUSH;
               end else begin
                  state_nxt_s = STREAM;
               end
            end else begin
               state_nxt_s = STREAM;
            end
         end
         FLUSH: begin
            adv_s = 1'b1;
            if (flush_cnt_r == FL_ONE) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = FLUSH;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Tile length latch, accepted-step counter and flush countdown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_len_r     <= {K_W{1'b0}};
         step_cnt_r  <= {K_W{1'b0}};
         flush_cnt_r <= {FL_W{1'b0}};
      end else begin
         if ((state_r == IDLE) && start && (k_len != {K_W{1'b0}})) begin
            k_len_r    <= k_len;
            step_cnt_r <= {K_W{1'b0}};
         end else if (inject_s) begin
            step_cnt_r <= step_cnt_r + K_ONE;
         end else begin
            step_cnt_r <= step_cnt_r;
         end
         if (last_step_s) begin
            flush_cnt_r <= FLUSH_LEN;
         end else if (state_r == FLUSH) begin
            flush_cnt_r <= flush_cnt_r - FL_ONE;
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign inj_a_s = inject_s ? a_vec : {(N*W){1'b0}};
   assign inj_b_s = inject_s ? b_vec : {(N*W){1'b0}};

   // Lane i is a chain of i+1 registers, so its edge value trails lane 0 by i advances.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [W-1:0] west_chain_r  [0:i];
      logic [W-1:0] north_chain_r [0:i];

      // Skew chain shift, gated by the advance.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int j = 0; j <= i; j++) begin
               west_chain_r[j]  <= {W{1'b0}};
               north_chain_r[j] <= {W{1'b0}};
            end
         end else if (adv_s) begin
            west_chain_r[0]  <= inj_a_s[i*W +: W];
            north_chain_r[0] <= inj_b_s[i*W +: W];
            for (int j = 1; j <= i; j++) begin
               west_chain_r[j]  <= west_chain_r[j-1];
               north_chain_r[j] <= north_chain_r[j-1];
            end
         end
      end

      assign west_out[i*W +: W]  = west_chain_r[i];
      assign north_out[i*W +: W] = north_chain_r[i];
   end

   // Clock-enable lags the advance so the array samples each edge value after it settles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_r   <= 1'b0;
         done_r <= 1'b0;
      end else begin
         ce_r   <= adv_s;
         done_r <= (state_nxt_s == DONE);
      end
   end

   assign ce       = ce_r;
   assign done     = done_r;
   assign in_ready = (state_r == STREAM);
   assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: scoreboard of per-cycle edge/ce/done expectations
// plus a behavioural 4x4 MAC grid for the end-to-end product check.
module tb_systolic_feeder;
   localparam int N   = 4;
   localparam int W   = 16;
   localparam int K_W = 8;
   localparam int VW  = N * W;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [K_W-1:0]  k_len;
   logic            in_valid;
   logic            in_ready;
   logic [VW-1:0]   a_vec;
   logic [VW-1:0]   b_vec;
   logic [VW-1:0]   west_out;
   logic [VW-1:0]   north_out;
   logic            ce;
   logic            busy;
   logic            done;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic          ce;
      logic          done;
      logic [VW-1:0] west;
      logic [VW-1:0] north;
   } exp_t;

   exp_t          exp_q[$];
   logic [VW-1:0] hist_a[$];
   logic [VW-1:0] hist_b[$];
   logic [VW-1:0] src_a[$];
   logic [VW-1:0] src_b[$];

   logic          pe_clr;
   logic [W-1:0]  pa  [N][N];
   logic [W-1:0]  pb  [N][N];
   logic [W-1:0]  ain [N][N];
   logic [W-1:0]  bin [N][N];
   logic [31:0]   acc [N][N];

   systolic_feeder #(.N(N), .W(W), .K_W(K_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
      .west_out(west_out), .north_out(north_out), .ce(ce), .busy(busy), .done(done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference MAC grid: A flows east, B flows south, accumulate on ce.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (j == 0) ain[i][j] = west_out[i*W +: W];
            else        ain[i][j] = pa[i][j-1];
            if (i == 0) bin[i][j] = north_out[j*W +: W];
            else        bin[i][j] = pb[i-1][j];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (pe_clr) begin
               acc[i][j] <= 32'd0;
               pa[i][j]  <= '0;
               pb[i][j]  <= '0;
            end else if (ce) begin
               acc[i][j] <= acc[i][j] + 32'(ain[i][j]) * 32'(bin[i][j]);
               pa[i][j]  <= ain[i][j];
               pb[i][j]  <= bin[i][j];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VW-1:0] rnd_vec();
      return {$urandom, $urandom};
   endfunction

   // Expected edge vector after cnt advances: lane i shows the injection from advance cnt-i.
   function automatic logic [VW-1:0] lanes(input bit use_b, input int cnt);
      logic [VW-1:0] r;
      logic [VW-1:0] h;
      int idx;
      r = '0;
      for (int i = 0; i < N; i++) begin
         idx = cnt - 1 - i;
         if (idx >= 0) begin
            h = use_b ? hist_b[idx] : hist_a[idx];
            r[i*W +: W] = h[i*W +: W];
         end
      end
      return r;
   endfunction

   task automatic pop_cmp();
      exp_t e;
      n_chk++;
      assert (exp_q.size() != 0) else begin
         n_fail++;
         $error("FAIL sb_empty observed=0 expected=1");
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("ce", ce, e.ce);
         chk("done", done, e.done);
         chk("west", west_out, e.west);
         chk("north", north_out, e.north);
      end
   endtask

   task automatic run_tile(input int k, input logic [31:0] vpat, input bit mid_start);
      int   taken;
      int   slot;
      int   adv_cnt;
      int   ce_seen;
      logic v;
      taken = 0; slot = 0; adv_cnt = 0; ce_seen = 0;
      hist_a.delete();
      hist_b.delete();
      start = 1'b1;
      k_len = k[K_W-1:0];
      tick();
      start = 1'b0;
      k_len = 8'd200;
      chk("busy_stream", busy, 1'b1);
      while (taken < k) begin
         v = (slot < 32) ? vpat[slot] : 1'b1;
         slot++;
         chk("in_ready_stream", in_ready, 1'b1);
         in_valid = v;
         if (mid_start && slot == 2) begin
            start = 1'b1;
            k_len = 8'd5;
         end
         if (v) begin
            a_vec = src_a.pop_front();
            b_vec = src_b.pop_front();
            hist_a.push_back(a_vec);
            hist_b.push_back(b_vec);
            adv_cnt++;
            taken++;
         end else begin
            a_vec = rnd_vec();
            b_vec = rnd_vec();
         end
         exp_q.push_back('{ce: v, done: 1'b0, west: lanes(1'b0, adv_cnt), north: lanes(1'b1, adv_cnt)});
         tick();
         in_valid = 1'b0;
         start    = 1'b0;
         ce_seen += int'(ce);
         pop_cmp();
      end
      for (int f = 0; f < 2*N-2; f++) begin
         chk("in_ready_flush", in_ready, 1'b0);
         in_valid = 1'($urandom);
         a_vec    = rnd_vec();
         b_vec    = rnd_vec();
         hist_a.push_back('0);
         hist_b.push_back('0);
         adv_cnt++;
         exp_q.push_back('{ce: 1'b1, done: (f == 2*N-3), west: lanes(1'b0, adv_cnt), north: lanes(1'b1, adv_cnt)});
         tick();
         ce_seen += int'(ce);
         pop_cmp();
      end
      in_valid = 1'b0;
      exp_q.push_back('{ce: 1'b0, done: 1'b0, west: lanes(1'b0, adv_cnt), north: lanes(1'b1, adv_cnt)});
      tick();
      pop_cmp();
      chk("busy_idle", busy, 1'b0);
      chk("ce_total", ce_seen, k + 2*N - 2);
   endtask

   initial begin
      pe_clr   = 1'b1;
      rst_n    = 1'b0;
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      k_len    = 8'($urandom);
      a_vec    = rnd_vec();
      b_vec    = rnd_vec();
      #3;
      chk("rst_west", west_out, '0);
      chk("rst_north", north_out, '0);
      chk("rst_ce", ce, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      tick();
      start = 1'b0; in_valid = 1'b0; k_len = 8'd0; pe_clr = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("idle_ce", ce, 1'b0);
         chk("idle_busy", busy, 1'b0);
      end

      // Single k-step with distinct lane values.
      src_a.push_back({16'd4, 16'd3, 16'd2, 16'd1});
      src_b.push_back({16'd8, 16'd7, 16'd6, 16'd5});
      run_tile(1, 32'h0000_0001, 1'b0);

      // Backpressure: in_valid 1,0,0,1,0,1.
      for (int s = 0; s < 3; s++) begin
         src_a.push_back(rnd_vec());
         src_b.push_back(rnd_vec());
      end
      run_tile(3, 32'h0000_0029, 1'b0);

      // Zero-length tile, start held through DONE and into IDLE.
      start = 1'b1;
      k_len = 8'd0;
      tick();
      chk("z_done", done, 1'b1);
      chk("z_ce", ce, 1'b0);
      chk("z_in_ready", in_ready, 1'b0);
      chk("z_busy", busy, 1'b1);
      tick();
      chk("z_done_ignored", done, 1'b0);
      chk("z_busy_idle", busy, 1'b0);
      chk("z_ce2", ce, 1'b0);
      tick();
      start = 1'b0;
      chk("z_restart_done", done, 1'b1);
      chk("z_restart_in_ready", in_ready, 1'b0);
      tick();
      chk("z_end_done", done, 1'b0);
      chk("z_end_ce", ce, 1'b0);

      // start pulsed mid-STREAM must not retarget the tile.
      for (int s = 0; s < 3; s++) begin
         src_a.push_back(rnd_vec());
         src_b.push_back(rnd_vec());
      end
      run_tile(3, 32'hFFFF_FFFF, 1'b1);

      // Asynchronous reset in the middle of FLUSH.
      start = 1'b1;
      k_len = 8'd2;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      a_vec = rnd_vec(); b_vec = rnd_vec();
      tick();
      a_vec = rnd_vec(); b_vec = rnd_vec();
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("mf_ce", ce, 1'b1);
      chk("mf_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mf_rst_west", west_out, '0);
      chk("mf_rst_north", north_out, '0);
      chk("mf_rst_ce", ce, 1'b0);
      chk("mf_rst_busy", busy, 1'b0);
      chk("mf_rst_done", done, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("mf_post_busy", busy, 1'b0);
      for (int s = 0; s < 2; s++) begin
         src_a.push_back(rnd_vec());
         src_b.push_back(rnd_vec());
      end
      run_tile(2, 32'h0000_0003, 1'b0);

      // End-to-end: A = identity, B = 1..16 row-major; each PE must end at B[i][j].
      pe_clr = 1'b1;
      tick();
      pe_clr = 1'b0;
      for (int s = 0; s < N; s++) begin
         logic [VW-1:0] av;
         logic [VW-1:0] bv;
         av = '0;
         bv = '0;
         for (int l = 0; l < N; l++) begin
            av[l*W +: W] = (l == s) ? 16'd1 : 16'd0;
            bv[l*W +: W] = 16'(4*s + l + 1);
         end
         src_a.push_back(av);
         src_b.push_back(bv);
      end
      run_tile(4, 32'hFFFF_FFFF, 1'b0);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            chk($sformatf("pe_%0d_%0d", i, j), acc[i][j], 32'(4*i + j + 1));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
